rice_core_pipeline_controller: RTL
==================================

# rice_core_pipeline_controller

Central stall/flush sequencer for the rice core pipeline. Collects redirect, trap, memory-wait and load-use hazard requests from the ID and EX stages, prioritises them, and drives the pipeline-wide `stall`, `flush` and `flush_pc` controls plus an EX bubble. A small FSM holds stalls across multi-cycle data-bus accesses and stretches flushes to a configurable length.

## Interface
Parameters:
- `XLEN`, 32: datapath and PC width.
- `FLUSH_CYCLES`, 1: cycles `o_flush` stays asserted per redirect; legal range 1..4.

Ports:
- `i_clk`  input  1  clock.
- `i_rst_n`  input  1  reset; asynchronous, active-low.
- `i_ex_valid`  input  1  EX holds a valid instruction.
- `i_ex_trap`  input  1  EX instruction raised an exception.
- `i_trap_vector`  input  XLEN  trap handler base (mtvec).
- `i_ex_branch_taken`  input  1  EX resolved a taken branch/jump.
- `i_ex_branch_target`  input  XLEN  redirect target.
- `i_ex_mem_req`  input  1  EX instruction is a load/store.
- `i_mem_ack`  input  1  data bus completes the access this cycle.
- `i_id_load_use`  input  1  ID instruction reads the destination of the EX load.
- `o_stall`  output  1  freeze IF and ID.
- `o_bubble`  output  1  inject a NOP into EX in place of the ID result.
- `o_flush`  output  1  invalidate IF/ID contents.
- `o_flush_pc`  output  XLEN  fetch restart address; valid while `o_flush`=1.
- `o_busy`  output  1  FSM is not in RUN.

## Operation
- FSM states: RUN, MEM_WAIT, FLUSH.
- Request priority, evaluated only when `i_ex_valid`=1, except load-use: trap > branch > memory wait > load-use.
- RUN:
  - Trap: `o_flush`=1 and `o_flush_pc`=`{i_trap_vector[XLEN-1:2],2'b00}`. Go to FLUSH if `FLUSH_CYCLES`>1, else stay in RUN.
  - Branch: `o_flush`=1 and `o_flush_pc`=`{i_ex_branch_target[XLEN-1:1],1'b0}`. Next state follows the same rule as trap.
  - Memory request with `i_mem_ack`=0: `o_stall`=1, go to MEM_WAIT. With `i_mem_ack`=1 in the same cycle: no stall.
  - Load-use only: `o_stall`=1 and `o_bubble`=1 for exactly that cycle; stay in RUN.
- MEM_WAIT:
  - `o_stall`=1 every cycle until `i_mem_ack`.
  - On the ack cycle, `o_stall`=0 and return to RUN.
  - `i_ex_trap` (bus fault) flushes to the trap vector, regardless of ack, and moves to FLUSH or RUN per `FLUSH_CYCLES`.
- FLUSH:
  - `o_flush`=1 and `o_flush_pc` holds the registered address.
  - A down-counter loaded with `FLUSH_CYCLES-2` on entry returns the FSM to RUN after it reaches 0.
  - All requests are ignored in this state; EX is being invalidated.
- `o_flush`=1 always forces `o_stall`=0 and `o_bubble`=0.
- `o_flush_pc` is registered on each redirect. It is driven from the live inputs in the request cycle and from the register afterwards. Its value is don't-care while `o_flush`=0, but holds the last redirect.
- `o_busy` = (state != RUN).

## Timing
- Reset values: state RUN; `o_stall`, `o_bubble`, `o_flush`, `o_busy` = 0; `o_flush_pc` = 0; flush counter = 0.
- Reset asserted mid-MEM_WAIT or mid-FLUSH drops all outputs to 0 asynchronously. The FSM resumes in RUN on the first edge after deassertion.
- `o_stall`, `o_bubble` and the first `o_flush` cycle are combinational from the inputs (zero latency). Later flush cycles and `o_busy` come from registers.
- A redirect produces exactly `FLUSH_CYCLES` consecutive `o_flush` cycles.
- A memory stall lasts from the request cycle through the cycle before ack. Stall length = ack latency.

## Configuration
- `RICE_CORE_PIPELINE_CTRL_PERF_EN` defined:
  - Adds outputs `o_stall_count` [31:0] and `o_flush_count` [31:0].
  - Each is a saturating counter of cycles with `o_stall`=1 / `o_flush`=1.
  - Both reset to 0.
- Undefined: the counters and ports are absent; behaviour is otherwise identical.

## Test plan
- Reset, then idle with all inputs 0 -> all outputs 0 and `o_busy`=0 for 10 cycles.
- Branch in RUN with target 0x0000_0103 and `FLUSH_CYCLES`=2 -> `o_flush`=1 for 2 cycles, `o_flush_pc`=0x0000_0102 both cycles, then RUN.
- Load with ack 3 cycles later -> `o_stall`=1 for 3 cycles, 0 on the ack cycle; `o_busy`=1 during the wait.
- Trap and branch in the same cycle, trap vector 0x8000_0041 -> `o_flush_pc`=0x8000_0040 and `o_stall`=0.
- Load-use alone -> `o_stall`=`o_bubble`=1 for exactly 1 cycle. Load-use coincident with branch -> flush only, `o_bubble`=0.
- `i_rst_n` pulsed low during MEM_WAIT -> `o_stall` goes to 0 immediately; with the perf macro enabled, the counters read 0 after reset.

Source files
------------

// File: rtl/rice_core_pipeline_controller.sv
// rice_core_pipeline_controller
//
// Central stall/flush sequencer for the rice core pipeline. Prioritises
// trap > branch > memory wait > load-use requests from EX/ID and drives the
// pipeline-wide stall, flush and EX bubble controls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; requests evaluated combinationally
// MEM_WAIT | data-bus access outstanding; stall IF/ID until ack
// FLUSH    | extra flush cycles after a redirect (FLUSH_CYCLES > 1)
//
// Parameters:
//   XLEN          datapath / PC width
//   FLUSH_CYCLES  o_flush cycles per redirect, 1..4
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_ex_valid                EX holds a valid instruction
//   i_ex_trap, i_trap_vector  EX exception and handler base
//   i_ex_branch_taken/target  EX taken branch and its target
//   i_ex_mem_req, i_mem_ack   EX load/store and bus completion
//   i_id_load_use             ID depends on the EX load result
//   o_stall, o_bubble         freeze IF/ID, insert NOP into EX
//   o_flush, o_flush_pc       invalidate IF/ID, fetch restart address
//   o_busy                    FSM not in RUN
//   o_stall_count/o_flush_count  saturating cycle counters, present only
//                                when RICE_CORE_PIPELINE_CTRL_PERF_EN is defined
module rice_core_pipeline_controller #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ex_valid,
  input  logic            i_ex_trap,
  input  logic [XLEN-1:0] i_trap_vector,
  input  logic            i_ex_branch_taken,
  input  logic [XLEN-1:0] i_ex_branch_target,
  input  logic            i_ex_mem_req,
  input  logic            i_mem_ack,
  input  logic            i_id_load_use,
`ifdef RICE_CORE_PIPELINE_CTRL_PERF_EN
  output logic [31:0]     o_stall_count,
  output logic [31:0]     o_flush_count,
`endif
  output logic            o_stall,
  output logic            o_bubble,
  output logic            o_flush,
  output logic [XLEN-1:0] o_flush_pc,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  // The redirect cycle itself is the first flush cycle, so the counter only
  // covers the remaining FLUSH_CYCLES-1 cycles spent in FLUSH.
  localparam int              CNT_LOAD_I  = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam logic [1:0]      CNT_LOAD    = 2'(CNT_LOAD_I);
  localparam state_t          REDIR_STATE = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
  localparam logic [XLEN-1:0] TRAP_MASK   = ~XLEN'(3);
  localparam logic [XLEN-1:0] BR_MASK     = ~XLEN'(1);

  state_t          r_state, w_next;
  logic [1:0]      r_cnt, w_cnt_next;
  logic [XLEN-1:0] r_flush_pc, w_redir_pc;
  logic            w_redirect, w_stall, w_bubble, w_flush;
  logic            w_trap, w_branch;

  assign w_trap   = i_ex_valid & i_ex_trap;
  assign w_branch = i_ex_valid & i_ex_branch_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_cnt      <= 2'd0;
      r_flush_pc <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_redirect) r_flush_pc <= w_redir_pc;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall    = 1'b0;
    w_bubble   = 1'b0;
    w_flush    = 1'b0;
    w_redirect = 1'b0;
    w_redir_pc = r_flush_pc;
    case (r_state)
      S_RUN: begin
        if (w_trap) begin
          w_redirect = 1'b1;
          w_redir_pc = i_trap_vector & TRAP_MASK;
        end else if (w_branch) begin
          w_redirect = 1'b1;
          w_redir_pc = i_ex_branch_target & BR_MASK;
        end else if (i_ex_valid && i_ex_mem_req && !i_mem_ack) begin
          w_stall = 1'b1;
          w_next  = S_MEM_WAIT;
        end else if (i_id_load_use) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // A bus fault arrives as a trap on the waiting instruction.
        if (w_trap) begin
          w_redirect = 1'b1;
          w_redir_pc = i_trap_vector & TRAP_MASK;
        end else if (i_mem_ack) begin
          w_next = S_RUN;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        if (r_cnt == 2'd0) w_next = S_RUN;
        else               w_cnt_next = r_cnt - 2'd1;
      end
      default: w_next = S_RUN;
    endcase
    if (w_redirect) begin
      w_flush    = 1'b1;
      w_next     = REDIR_STATE;
      w_cnt_next = CNT_LOAD;
    end
  end

  // Combinational outputs are qualified by reset so an asynchronous reset
  // silences them even while request inputs are still asserted.
  assign o_flush    = w_flush & i_rst_n;
  assign o_stall    = w_stall & ~w_flush & i_rst_n;
  assign o_bubble   = w_bubble & ~w_flush & i_rst_n;
  assign o_flush_pc = (w_redirect && i_rst_n) ? w_redir_pc : r_flush_pc;
  assign o_busy     = (r_state != S_RUN);

`ifdef RICE_CORE_PIPELINE_CTRL_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_count <= 32'd0;
      o_flush_count <= 32'd0;
    end else begin
      if (o_stall && (o_stall_count != 32'hFFFF_FFFF)) o_stall_count <= o_stall_count + 32'd1;
      if (o_flush && (o_flush_count != 32'hFFFF_FFFF)) o_flush_count <= o_flush_count + 32'd1;
    end
  end
`endif

endmodule
